hazard_unit: RTL

- Hazard-detection and forwarding block for the 5-stage MIPS pipeline; sits beside the controller/datapath.
- Consumes the controller's per-stage control bits (regwrite, memtoreg, branch, jr) and the register indices from the datapath.
- Produces the stall/flush inputs of the controller's pipeline registers and the datapath forwarding selects.
- Owns a multi-cycle divider occupancy FSM that holds the pipeline while a DIV/DIVU in E completes.

---
 rtl/hazard_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Hazard detection, forwarding selects and divider occupancy tracking
// for the five-stage MIPS pipeline.
module hazard_unit #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       jrD,
    input  logic       divE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushE,
    output logic       stallM,
    output logic       flushM,
    output logic       stallW,
    output logic       flushW,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       divstartE,
    output logic       divbusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES - 1);

    div_state_e state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    logic lwstall;
    logic branchstall;
    logic divstall;
    logic div_start;
    logic use_rs;
    logic use_rt;

    // Register $0 is hardwired, so it can never carry a dependency.
    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] wm,
                                           input logic       rwm,
                                           input logic [4:0] ww,
                                           input logic       rww);
        logic [1:0] sel;
        sel = 2'b00;
        if (rwm && hit(src, wm)) begin
            sel = 2'b10;
        end else if (rww && hit(src, ww)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (divE) begin
                    state_d   = BUSY;
                    cnt_d     = CNT_INIT;
                    div_start = 1'b1;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The divide leaves E now; a following div restarts from IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        use_rs = branchD | jrD;
        use_rt = branchD;

        lwstall = memtoregE & regwriteE &
                  (hit(writeregE, rsD) | hit(writeregE, rtD));

        branchstall =
            (regwriteE & ((use_rs & hit(writeregE, rsD)) |
                          (use_rt & hit(writeregE, rtD)))) |
            (memtoregM & ((use_rs & hit(writeregM, rsD)) |
                          (use_rt & hit(writeregM, rtD))));

        divstall = ((state_q == IDLE) & divE) | (state_q == BUSY);
    end

    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushE    = 1'b0;
        stallM    = 1'b0;
        flushM    = 1'b0;
        stallW    = 1'b0;
        flushW    = 1'b0;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        divstartE = 1'b0;
        divbusy   = 1'b0;
        if (!rst) begin
            stallF    = lwstall | branchstall | divstall;
            stallD    = lwstall | branchstall | divstall;
            stallE    = divstall;
            // A held E stage must keep its instruction, so no bubble there.
            flushE    = (lwstall | branchstall) & ~divstall;
            flushM    = divstall;
            forwardAD = regwriteM & hit(rsD, writeregM);
            forwardBD = regwriteM & hit(rtD, writeregM);
            forwardAE = fwd_sel(rsE, writeregM, regwriteM,
                                writeregW, regwriteW);
            forwardBE = fwd_sel(rtE, writeregM, regwriteM,
                                writeregW, regwriteW);
            divstartE = div_start;
            divbusy   = (state_q != IDLE);
        end
    end

endmodule
